// File: rtl/ra_64x72_2r1w_ctl_pkg.sv
// rtl/ra_64x72_2r1w_ctl_pkg.sv - shared widths and FSM encodings for the 64x72 2R1W array controller
package ra_64x72_2r1w_ctl_pkg;
    localparam int ADR_W = 6;
    localparam int DAT_W = 72;
    localparam int ROWS  = 64;
    // Client-id width sized for the largest legal NREQ (8).
    localparam int ID_W  = 3;

    typedef enum logic {
        RA_ST_INIT = 1'b0,
        RA_ST_RUN  = 1'b1
    } ra_state_t;
endpackage

// File: rtl/ra_rr_pick2.sv
// rtl/ra_rr_pick2.sv - combinational round-robin picker granting up to two requesters per cycle
module ra_rr_pick2
    import ra_64x72_2r1w_ctl_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt0_val,
    output logic [ID_W-1:0] gnt0_idx,
    output logic            gnt1_val,
    output logic [ID_W-1:0] gnt1_idx,
    output logic [ID_W-1:0] ptr_nxt
);
    logic [2*NREQ-1:0] req2;
    logic [2*NREQ-1:0] rot;
    logic [ID_W:0]     idx;
    logic [ID_W:0]     nxt;

    always_comb begin
        req2     = {req, req};
        // Rotating the doubled vector puts the ptr client at bit 0.
        rot      = req2 >> ptr;
        idx      = '0;
        nxt      = '0;
        gnt0_val = 1'b0;
        gnt0_idx = '0;
        gnt1_val = 1'b0;
        gnt1_idx = '0;
        ptr_nxt  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NREQ)) idx = idx - (ID_W+1)'(NREQ);
            if (rot[k]) begin
                if (!gnt0_val) begin
                    gnt0_val = 1'b1;
                    gnt0_idx = idx[ID_W-1:0];
                end else if (!gnt1_val) begin
                    gnt1_val = 1'b1;
                    gnt1_idx = idx[ID_W-1:0];
                end
            end
        end
        if (gnt0_val) begin
            nxt = {1'b0, (gnt1_val ? gnt1_idx : gnt0_idx)} + 1'b1;
            if (nxt == (ID_W+1)'(NREQ)) nxt = '0;
            ptr_nxt = nxt[ID_W-1:0];
        end
    end
endmodule

// File: rtl/ra_64x72_2r1w_ctl.sv
// rtl/ra_64x72_2r1w_ctl.sv - read arbiter, write pass-through and clear sequencer for the 64x72 2R1W array (option RA_WR_BYPASS_EN)
module ra_64x72_2r1w_ctl
    import ra_64x72_2r1w_ctl_pkg::*;
#(
    parameter int               NREQ     = 3,
    parameter int               RD_LAT   = 2,
    parameter logic [DAT_W-1:0] INIT_VAL = 72'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    output logic                    init_busy,
    input  logic [NREQ-1:0]         rq_val,
    input  logic [NREQ*ADR_W-1:0]   rq_adr,
    output logic [NREQ-1:0]         rq_rdy,
    output logic [NREQ-1:0]         rs_val,
    output logic [NREQ*DAT_W-1:0]   rs_dat,
    input  logic                    wr_val,
    input  logic [ADR_W-1:0]        wr_adr,
    input  logic [DAT_W-1:0]        wr_dat,
    output logic                    wr_rdy,
    output logic                    ra_rd_enb_0,
    output logic [ADR_W-1:0]        ra_rd_adr_0,
    input  logic [DAT_W-1:0]        ra_rd_dat_0,
    output logic                    ra_rd_enb_1,
    output logic [ADR_W-1:0]        ra_rd_adr_1,
    input  logic [DAT_W-1:0]        ra_rd_dat_1,
    output logic                    ra_wr_enb_0,
    output logic [ADR_W-1:0]        ra_wr_adr_0,
    output logic [DAT_W-1:0]        ra_wr_dat_0
);
    ra_state_t          state_q, state_d;
    logic [ADR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, ptr_nxt;
    logic               g0_val, g1_val;
    logic [ID_W-1:0]    g0_idx, g1_idx;
    logic [1:0]         rd_enb;
    logic [ADR_W-1:0]   rd_adr [2];
    logic [ID_W-1:0]    rd_id  [2];
    logic [DAT_W-1:0]   ret_dat [2];
    logic [RD_LAT-1:0]  p_val  [2];
    logic [ID_W-1:0]    p_id   [2][RD_LAT];
    logic [NREQ*DAT_W-1:0] rs_dat_q;

    ra_rr_pick2 #(.NREQ(NREQ)) u_pick (
        .req      (rq_val),
        .ptr      (rr_ptr_q),
        .gnt0_val (g0_val),
        .gnt0_idx (g0_idx),
        .gnt1_val (g1_val),
        .gnt1_idx (g1_idx),
        .ptr_nxt  (ptr_nxt)
    );

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        init_busy   = 1'b0;
        wr_rdy      = 1'b0;
        rq_rdy      = '0;
        rd_enb      = '0;
        ra_wr_enb_0 = 1'b0;
        ra_wr_adr_0 = wr_adr;
        ra_wr_dat_0 = wr_dat;
        if (!reset) begin
            case (state_q)
                RA_ST_INIT: begin
                    init_busy   = 1'b1;
                    ra_wr_enb_0 = 1'b1;
                    ra_wr_adr_0 = clr_cnt_q;
                    ra_wr_dat_0 = INIT_VAL;
                    clr_cnt_d   = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADR_W'(ROWS-1)) state_d = RA_ST_RUN;
                end
                RA_ST_RUN: begin
                    wr_rdy      = 1'b1;
                    ra_wr_enb_0 = wr_val;
                    rd_enb      = {g1_val, g0_val};
                    rr_ptr_d    = ptr_nxt;
                    for (int i = 0; i < NREQ; i++)
                        rq_rdy[i] = (g0_val && g0_idx == ID_W'(i)) || (g1_val && g1_idx == ID_W'(i));
                    // Grants made in the clear cycle are already on the array ports.
                    if (clear) begin
                        state_d   = RA_ST_INIT;
                        clr_cnt_d = '0;
                    end
                end
                default: state_d = RA_ST_INIT;
            endcase
        end
    end

    always_comb begin
        rd_adr[0] = rq_adr[ADR_W-1:0];
        rd_adr[1] = rq_adr[ADR_W-1:0];
        for (int i = 0; i < NREQ; i++) begin
            if (g0_idx == ID_W'(i)) rd_adr[0] = rq_adr[ADR_W*i +: ADR_W];
            if (g1_idx == ID_W'(i)) rd_adr[1] = rq_adr[ADR_W*i +: ADR_W];
        end
    end

    assign rd_id[0]    = g0_idx;
    assign rd_id[1]    = g1_idx;
    assign ra_rd_enb_0 = rd_enb[0];
    assign ra_rd_enb_1 = rd_enb[1];
    assign ra_rd_adr_0 = rd_adr[0];
    assign ra_rd_adr_1 = rd_adr[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RA_ST_INIT;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Response pipes track which client each port's read belongs to until the data lands.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            p_id[p][0] <= rd_id[p];
            for (int s = 1; s < RD_LAT; s++) p_id[p][s] <= p_id[p][s-1];
            if (reset) begin
                p_val[p] <= '0;
            end else begin
                p_val[p][0] <= rd_enb[p];
                for (int s = 1; s < RD_LAT; s++) p_val[p][s] <= p_val[p][s-1];
            end
        end
    end

`ifdef RA_WR_BYPASS_EN
    logic [1:0]        byp_hit;
    logic [RD_LAT-1:0] p_byp  [2];
    logic [DAT_W-1:0]  p_bdat [2][RD_LAT];

    always_comb begin
        for (int p = 0; p < 2; p++)
            byp_hit[p] = rd_enb[p] && ra_wr_enb_0 && (wr_adr == rd_adr[p]);
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            p_byp[p][0]  <= byp_hit[p];
            p_bdat[p][0] <= wr_dat;
            for (int s = 1; s < RD_LAT; s++) begin
                p_byp[p][s]  <= p_byp[p][s-1];
                p_bdat[p][s] <= p_bdat[p][s-1];
            end
        end
    end

    assign ret_dat[0] = p_byp[0][RD_LAT-1] ? p_bdat[0][RD_LAT-1] : ra_rd_dat_0;
    assign ret_dat[1] = p_byp[1][RD_LAT-1] ? p_bdat[1][RD_LAT-1] : ra_rd_dat_1;
`else
    assign ret_dat[0] = ra_rd_dat_0;
    assign ret_dat[1] = ra_rd_dat_1;
`endif

    always_comb begin
        rs_val = '0;
        rs_dat = rs_dat_q;
        for (int p = 0; p < 2; p++) begin
            if (p_val[p][RD_LAT-1]) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (p_id[p][RD_LAT-1] == ID_W'(i)) begin
                        rs_val[i]                = 1'b1;
                        rs_dat[DAT_W*i +: DAT_W] = ret_dat[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rs_dat_q <= '0;
        else       rs_dat_q <= rs_dat;
    end
endmodule

// File: tb/tb_ra_64x72_2r1w_ctl.sv
// tb/tb_ra_64x72_2r1w_ctl.sv - directed table-driven bench for ra_64x72_2r1w_ctl with a behavioural 2R1W array
module tb_ra_64x72_2r1w_ctl;
    localparam int          NREQ   = 3;
    localparam int          RD_LAT = 2;
    localparam logic [71:0] IV     = 72'h5A_0123_4567_89AB_CDEF;
    localparam logic [71:0] DA5    = 72'hA5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [71:0] D7     = 72'hD7_0000_1111_2222_3333;
    localparam logic [71:0] D9     = 72'h9D_4444_5555_6666_7777;
    localparam logic [71:0] DX     = 72'h3C_C3C3_0F0F_F0F0_1234;
    localparam logic [71:0] D55    = 72'h55_5555_5555_5555_5555;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              init_busy;
    logic [NREQ-1:0]   rq_val = '0;
    logic [NREQ*6-1:0] rq_adr = '0;
    logic [NREQ-1:0]   rq_rdy, rs_val;
    logic [NREQ*72-1:0] rs_dat;
    logic              wr_val = 1'b0;
    logic [5:0]        wr_adr = '0;
    logic [71:0]       wr_dat = '0;
    logic              wr_rdy;
    logic              ra_rd_enb_0, ra_rd_enb_1, ra_wr_enb_0;
    logic [5:0]        ra_rd_adr_0, ra_rd_adr_1, ra_wr_adr_0;
    logic [71:0]       ra_rd_dat_0, ra_rd_dat_1, ra_wr_dat_0;

    logic [71:0] mem [64];
    logic [71:0] q0, q1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] val;
        logic [2:0] rdy;
        logic       e0;
        logic [5:0] a0;
        logic       e1;
        logic [5:0] a1;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    ra_64x72_2r1w_ctl #(.NREQ(NREQ), .RD_LAT(RD_LAT), .INIT_VAL(IV)) dut (
        .clk(clk), .reset(reset), .clear(clear), .init_busy(init_busy),
        .rq_val(rq_val), .rq_adr(rq_adr), .rq_rdy(rq_rdy),
        .rs_val(rs_val), .rs_dat(rs_dat),
        .wr_val(wr_val), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_rdy(wr_rdy),
        .ra_rd_enb_0(ra_rd_enb_0), .ra_rd_adr_0(ra_rd_adr_0), .ra_rd_dat_0(ra_rd_dat_0),
        .ra_rd_enb_1(ra_rd_enb_1), .ra_rd_adr_1(ra_rd_adr_1), .ra_rd_dat_1(ra_rd_dat_1),
        .ra_wr_enb_0(ra_wr_enb_0), .ra_wr_adr_0(ra_wr_adr_0), .ra_wr_dat_0(ra_wr_dat_0)
    );

    // Array with registered read (two-cycle latency); a same-cycle write lands after the read samples.
    always @(posedge clk) begin
        if (ra_rd_enb_0) q0 <= mem[ra_rd_adr_0];
        if (ra_rd_enb_1) q1 <= mem[ra_rd_adr_1];
        ra_rd_dat_0 <= q0;
        ra_rd_dat_1 <= q1;
        if (ra_wr_enb_0) mem[ra_wr_adr_0] <= ra_wr_dat_0;
    end

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_read(input int c, input logic [5:0] a, input logic [71:0] exp, input string nm);
        logic [2:0] v;
        v = 3'b001 << c;
        rq_val = v;
        rq_adr[6*c +: 6] = a;
        mid();
        chk({nm, "_rdy"}, rq_rdy, v);
        cyc();
        rq_val = '0;
        mid();
        chk({nm, "_early"}, rs_val, 3'b000);
        cyc();
        mid();
        chk({nm, "_val"}, rs_val, v);
        chk({nm, "_dat"}, rs_dat[72*c +: 72], exp);
        cyc();
    endtask

    initial begin
        int n;
        tbl[0] = '{3'b111, 3'b011, 1'b1, 6'd10, 1'b1, 6'd11};
        tbl[1] = '{3'b111, 3'b101, 1'b1, 6'd12, 1'b1, 6'd10};
        tbl[2] = '{3'b111, 3'b110, 1'b1, 6'd11, 1'b1, 6'd12};
        tbl[3] = '{3'b111, 3'b011, 1'b1, 6'd10, 1'b1, 6'd11};
        tbl[4] = '{3'b010, 3'b010, 1'b1, 6'd11, 1'b0, 6'd0};
        tbl[5] = '{3'b001, 3'b001, 1'b1, 6'd10, 1'b0, 6'd0};
        tbl[6] = '{3'b000, 3'b000, 1'b0, 6'd0,  1'b0, 6'd0};
        tbl[7] = '{3'b101, 3'b101, 1'b1, 6'd12, 1'b1, 6'd10};
        tbl[8] = '{3'b011, 3'b011, 1'b1, 6'd11, 1'b1, 6'd10};

        // Reset with requests pending: nothing may be granted or enabled.
        reset  = 1'b1;
        rq_val = 3'b111;
        rq_adr = {6'd12, 6'd11, 6'd10};
        wr_val = 1'b1;
        wr_adr = 6'd40;
        wr_dat = '1;
        cyc();
        cyc();
        mid();
        chk("rst_rs_val", rs_val, 3'b000);
        chk("rst_rq_rdy", rq_rdy, 3'b000);
        chk("rst_wr_rdy", wr_rdy, 1'b0);
        chk("rst_wr_enb", ra_wr_enb_0, 1'b0);
        chk("rst_rd_enb", {ra_rd_enb_1, ra_rd_enb_0}, 2'b00);
        cyc();
        reset = 1'b0;

        // Clear walk after reset.
        for (int i = 0; i < 64; i++) begin
            mid();
            chk("init_busy", init_busy, 1'b1);
            chk("init_wr_enb", ra_wr_enb_0, 1'b1);
            chk("init_wr_adr", ra_wr_adr_0, 72'(i));
            chk("init_wr_dat", ra_wr_dat_0, IV);
            chk("init_rq_rdy", rq_rdy, 3'b000);
            chk("init_wr_rdy", wr_rdy, 1'b0);
            chk("init_rd_enb", {ra_rd_enb_1, ra_rd_enb_0}, 2'b00);
            cyc();
        end
        rq_val = '0;
        wr_val = 1'b0;
        mid();
        chk("run_busy", init_busy, 1'b0);
        chk("run_wr_rdy", wr_rdy, 1'b1);
        chk("run_wr_enb_idle", ra_wr_enb_0, 1'b0);
        cyc();

        // Arbitration table, rr_ptr starts at 0.
        for (int r = 0; r < 9; r++) begin
            rq_val = tbl[r].val;
            mid();
            chk($sformatf("tbl%0d_rdy", r), rq_rdy, tbl[r].rdy);
            chk($sformatf("tbl%0d_enb", r), {ra_rd_enb_1, ra_rd_enb_0}, {tbl[r].e1, tbl[r].e0});
            if (tbl[r].e0) chk($sformatf("tbl%0d_adr0", r), ra_rd_adr_0, tbl[r].a0);
            if (tbl[r].e1) chk($sformatf("tbl%0d_adr1", r), ra_rd_adr_1, tbl[r].a1);
            cyc();
        end
        rq_val = '0;
        cyc();
        cyc();
        cyc();

        // Write then read next cycle.
        wr_val = 1'b1;
        wr_adr = 6'd5;
        wr_dat = DA5;
        mid();
        chk("wr5_enb", ra_wr_enb_0, 1'b1);
        chk("wr5_adr", ra_wr_adr_0, 6'd5);
        chk("wr5_dat", ra_wr_dat_0, DA5);
        cyc();
        wr_val = 1'b0;
        do_read(1, 6'd5, DA5, "rd5");

        // Two clients on both ports in one cycle (rr_ptr now 2).
        wr_val = 1'b1;
        wr_adr = 6'd7;
        wr_dat = D7;
        cyc();
        wr_adr = 6'd9;
        wr_dat = D9;
        cyc();
        wr_val = 1'b0;
        rq_val = 3'b101;
        rq_adr = {6'd9, 6'd0, 6'd7};
        mid();
        chk("dual_rdy", rq_rdy, 3'b101);
        chk("dual_adr0", ra_rd_adr_0, 6'd9);
        chk("dual_adr1", ra_rd_adr_1, 6'd7);
        cyc();
        rq_val = '0;
        cyc();
        mid();
        chk("dual_val", rs_val, 3'b101);
        chk("dual_dat0", rs_dat[0 +: 72], D7);
        chk("dual_dat2", rs_dat[144 +: 72], D9);
        cyc();
        mid();
        chk("hold_val", rs_val, 3'b000);
        chk("hold_dat0", rs_dat[0 +: 72], D7);
        chk("hold_dat2", rs_dat[144 +: 72], D9);
        cyc();

        // Same-cycle read and write of row 3.
        wr_val = 1'b1;
        wr_adr = 6'd3;
        wr_dat = DX;
        rq_val = 3'b001;
        rq_adr[0 +: 6] = 6'd3;
        mid();
        chk("raw_rdy", rq_rdy, 3'b001);
        chk("raw_wr_enb", ra_wr_enb_0, 1'b1);
        cyc();
        wr_val = 1'b0;
        rq_val = '0;
        cyc();
        mid();
        chk("raw_val", rs_val, 3'b001);
`ifdef RA_WR_BYPASS_EN
        chk("raw_dat", rs_dat[0 +: 72], DX);
`else
        chk("raw_dat", rs_dat[0 +: 72], IV);
`endif
        cyc();
        do_read(0, 6'd3, DX, "rd3_after");

        // Clear with two reads in flight (rr_ptr now 1).
        wr_val = 1'b1;
        wr_adr = 6'd20;
        wr_dat = D55;
        cyc();
        wr_val = 1'b0;
        clear  = 1'b1;
        rq_val = 3'b110;
        rq_adr = {6'd5, 6'd20, 6'd0};
        mid();
        chk("clr_rdy", rq_rdy, 3'b110);
        cyc();
        clear  = 1'b0;
        rq_val = '0;
        mid();
        chk("clr_busy", init_busy, 1'b1);
        chk("clr_wr_adr", ra_wr_adr_0, 6'd0);
        chk("clr_early", rs_val, 3'b000);
        cyc();
        mid();
        chk("clr_resp_val", rs_val, 3'b110);
        chk("clr_resp_dat1", rs_dat[72 +: 72], D55);
        chk("clr_resp_dat2", rs_dat[144 +: 72], DA5);
        n = 1;
        for (int t = 0; t < 200; t++) begin
            if (init_busy !== 1'b1) break;
            n++;
            cyc();
            mid();
        end
        chk("clr_len", 72'(n), 72'd64);
        cyc();
        do_read(0, 6'd5,  IV, "post_clr5");
        do_read(1, 6'd20, IV, "post_clr20");
        do_read(2, 6'd63, IV, "post_clr63");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
